// File: rtl/ap_ctrl_txn_tracker.sv
// ap_ctrl_txn_tracker: pairs ap_ctrl_chain starts with completions and emits timestamped records (optional stall counter: TXN_STALL_COUNT_EN)
module ap_ctrl_txn_tracker #(
   parameter int TS_W        = 32,
   parameter int REC_DEPTH   = 8,
   parameter int START_DEPTH = 4
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            ap_start,
   input  logic            ap_ready,
   input  logic            ap_done,
   input  logic            ap_continue,
   input  logic            finish,
   output logic            rec_valid,
   input  logic            rec_ready,
   output logic [TS_W-1:0] rec_start_ts,
   output logic [TS_W-1:0] rec_end_ts,
   output logic [TS_W-1:0] rec_latency,
   output logic [TS_W-1:0] rec_interval,
   output logic [TS_W-1:0] rec_stall,
   output logic [15:0]     rec_index,
   output logic            overflow,
   output logic            proto_err,
   output logic            all_done
);
   localparam int SAW = START_DEPTH > 1 ? $clog2(START_DEPTH) : 1;
   localparam int SCW = $clog2(START_DEPTH + 1);
   localparam int RAW = $clog2(REC_DEPTH);
   localparam int RCW = $clog2(REC_DEPTH + 1);
   typedef struct packed {
      logic [TS_W-1:0] st;
      logic [TS_W-1:0] en;
      logic [TS_W-1:0] lat;
      logic [TS_W-1:0] itv;
      logic [TS_W-1:0] stl;
      logic [15:0]     idx;
   } rec_t;
   typedef struct packed {
      logic [TS_W-1:0] st;
      logic [TS_W-1:0] itv;
   } sq_t;
   logic [TS_W-1:0] ts_q, last_q, stall_cur;
   logic            have_q, ovf_q, perr_q, fin_q, adone_q;
   logic [15:0]     idx_q;
   sq_t             sq_q [START_DEPTH];
   logic [SAW-1:0]  s_rd_q, s_wr_q, s_rd_d, s_wr_d;
   logic [SCW-1:0]  s_cnt_q, s_cnt_d;
   rec_t            rf_q [REC_DEPTH];
   logic [RAW-1:0]  r_rd_q, r_wr_q;
   logic [RCW-1:0]  r_cnt_q, r_cnt_d;
   logic            s_ev, d_ev, s_empty, s_full, s_push, s_pop, r_full, r_push, r_pop;
   logic            ovf_d, perr_d, adone_d;
   logic [TS_W-1:0] itv_now;
   sq_t             s_head;
   rec_t            new_rec;
`ifdef TXN_STALL_COUNT_EN
   logic [TS_W-1:0] stall_q, stall_d;
   // Stall counter: counts done-backpressure cycles, saturates, restarts on each accepted done
   always_comb stall_d = d_ev ? '0 : (ap_done && !ap_continue && stall_q != '1) ? stall_q + TS_W'(1) : stall_q;
   // Stall counter register
   always_ff @(posedge clock or posedge reset)
      if (reset) stall_q <= '0;
      else stall_q <= stall_d;
   assign stall_cur = stall_q;
`else
   assign stall_cur = '0;
`endif
   // Event decode, queue/FIFO bookkeeping and record assembly
   always_comb begin
      s_ev    = ap_start & ap_ready;
      d_ev    = ap_done & ap_continue;
      s_empty = s_cnt_q == '0;
      s_full  = s_cnt_q == SCW'(START_DEPTH);
      itv_now = have_q ? ts_q - last_q : '0;
      s_head  = sq_q[s_rd_q];
      s_push  = s_ev & (d_ev ? !s_empty : !s_full);
      s_pop   = d_ev & !s_empty;
      s_rd_d  = !s_pop ? s_rd_q : (s_rd_q == SAW'(START_DEPTH - 1)) ? '0 : s_rd_q + SAW'(1);
      s_wr_d  = !s_push ? s_wr_q : (s_wr_q == SAW'(START_DEPTH - 1)) ? '0 : s_wr_q + SAW'(1);
      s_cnt_d = s_cnt_q + SCW'(s_push) - SCW'(s_pop);
      rec_valid = r_cnt_q != '0;
      r_full  = r_cnt_q == RCW'(REC_DEPTH);
      r_pop   = rec_valid & rec_ready;
      r_push  = d_ev & (!r_full | r_pop);
      r_cnt_d = r_cnt_q + RCW'(r_push) - RCW'(r_pop);
      new_rec.st  = s_empty ? ts_q : s_head.st;
      new_rec.en  = ts_q;
      new_rec.lat = ts_q - new_rec.st;
      new_rec.itv = !s_empty ? s_head.itv : s_ev ? itv_now : '0;
      new_rec.stl = stall_cur;
      new_rec.idx = idx_q;
      ovf_d   = ovf_q | (s_ev & !d_ev & s_full) | (d_ev & r_full & !r_pop);
      perr_d  = perr_q | (d_ev & !s_ev & s_empty);
      adone_d = adone_q | ((fin_q | finish) & (r_cnt_q == '0) & !d_ev);
   end
   // Timestamp, start queue, record FIFO and sticky status registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ts_q    <= '0;
         last_q  <= '0;
         have_q  <= 1'b0;
         idx_q   <= '0;
         s_rd_q  <= '0;
         s_wr_q  <= '0;
         s_cnt_q <= '0;
         r_rd_q  <= '0;
         r_wr_q  <= '0;
         r_cnt_q <= '0;
         ovf_q   <= 1'b0;
         perr_q  <= 1'b0;
         fin_q   <= 1'b0;
         adone_q <= 1'b0;
         for (int i = 0; i < START_DEPTH; i++) sq_q[i] <= '0;
         for (int i = 0; i < REC_DEPTH; i++) rf_q[i] <= '0;
      end else begin
         ts_q    <= ts_q + TS_W'(1);
         if (s_ev) begin
            last_q <= ts_q;
            have_q <= 1'b1;
         end
         if (s_push) sq_q[s_wr_q] <= '{st: ts_q, itv: itv_now};
         if (r_push) begin
            rf_q[r_wr_q] <= new_rec;
            r_wr_q       <= r_wr_q + RAW'(1);
         end
         if (r_pop) r_rd_q <= r_rd_q + RAW'(1);
         if (d_ev) idx_q <= idx_q + 16'd1;
         s_rd_q  <= s_rd_d;
         s_wr_q  <= s_wr_d;
         s_cnt_q <= s_cnt_d;
         r_cnt_q <= r_cnt_d;
         ovf_q   <= ovf_d;
         perr_q  <= perr_d;
         fin_q   <= fin_q | finish;
         adone_q <= adone_d;
      end
   end
   assign rec_start_ts = rf_q[r_rd_q].st;
   assign rec_end_ts   = rf_q[r_rd_q].en;
   assign rec_latency  = rf_q[r_rd_q].lat;
   assign rec_interval = rf_q[r_rd_q].itv;
   assign rec_stall    = rf_q[r_rd_q].stl;
   assign rec_index    = rf_q[r_rd_q].idx;
   assign overflow     = ovf_q;
   assign proto_err    = perr_q;
   assign all_done     = adone_q;
endmodule

// File: tb/tb_ap_ctrl_txn_tracker.sv
// tb_ap_ctrl_txn_tracker: directed self-checking bench for ap_ctrl_txn_tracker (TS_W=8)
module tb_ap_ctrl_txn_tracker;
   logic       clock = 0, reset = 1;
   logic       ap_start = 0, ap_ready = 0, ap_done = 0, ap_continue = 0, finish = 0, rec_ready = 0;
   logic       rec_valid, overflow, proto_err, all_done;
   logic [7:0] rec_start_ts, rec_end_ts, rec_latency, rec_interval, rec_stall;
   logic [15:0] rec_index;
   int checks = 0, errors = 0, cur = 0;
`ifdef TXN_STALL_COUNT_EN
   localparam int EXP_STL = 3;
`else
   localparam int EXP_STL = 0;
`endif
   ap_ctrl_txn_tracker #(.TS_W(8), .REC_DEPTH(8), .START_DEPTH(4)) dut (
      .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
      .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish),
      .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_start_ts(rec_start_ts),
      .rec_end_ts(rec_end_ts), .rec_latency(rec_latency), .rec_interval(rec_interval),
      .rec_stall(rec_stall), .rec_index(rec_index), .overflow(overflow),
      .proto_err(proto_err), .all_done(all_done)
   );
   always #5 clock = ~clock;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clock);
      #1;
      cur++;
   endtask
   task automatic do_reset();
      {ap_start, ap_ready, ap_done, ap_continue, finish, rec_ready} = '0;
      reset = 1;
      @(posedge clock);
      #1;
      reset = 0;
      cur = 0;
   endtask
   task automatic go_to(input int n);
      while (cur < n) tick();
   endtask
   task automatic ev(input int n, input logic s, input logic d);
      go_to(n);
      ap_start = s; ap_ready = s; ap_done = d; ap_continue = d;
      tick();
      {ap_start, ap_ready, ap_done, ap_continue} = '0;
   endtask
   task automatic pop_chk(input string tag, input int st, input int en, input int lat, input int itv, input int idx);
      chk({tag, ".valid"}, rec_valid, 1);
      chk({tag, ".start"}, rec_start_ts, st);
      chk({tag, ".end"}, rec_end_ts, en);
      chk({tag, ".lat"}, rec_latency, lat);
      chk({tag, ".itv"}, rec_interval, itv);
      chk({tag, ".idx"}, rec_index, idx);
      rec_ready = 1;
      tick();
      rec_ready = 0;
   endtask
   initial begin
      do_reset();
      chk("rst.valid", rec_valid, 0);
      chk("rst.ovf", overflow, 0);
      chk("rst.perr", proto_err, 0);
      chk("rst.adone", all_done, 0);
      chk("rst.start", rec_start_ts, 0);
      chk("rst.idx", rec_index, 0);
      // single transaction, consumer always ready
      rec_ready = 1;
      ev(5, 1, 0);
      go_to(17);
      chk("single.pre_valid", rec_valid, 0);
      ev(17, 0, 1);
      chk("single.valid18", rec_valid, 1);
      chk("single.start", rec_start_ts, 5);
      chk("single.end", rec_end_ts, 17);
      chk("single.lat", rec_latency, 12);
      chk("single.itv", rec_interval, 0);
      chk("single.idx", rec_index, 0);
      chk("single.stall", rec_stall, 0);
      tick();
      chk("single.valid19", rec_valid, 0);
      // pipelined
      do_reset();
      ev(2, 1, 0); ev(4, 1, 0); ev(6, 1, 0);
      ev(10, 0, 1); ev(12, 0, 1); ev(14, 0, 1);
      pop_chk("pipe0", 2, 10, 8, 0, 0);
      pop_chk("pipe1", 4, 12, 8, 2, 1);
      pop_chk("pipe2", 6, 14, 8, 2, 2);
      chk("pipe.empty", rec_valid, 0);
      chk("pipe.perr", proto_err, 0);
      // back-pressure: 9 bypass completions into an 8-deep FIFO
      do_reset();
      for (int k = 1; k <= 9; k++) ev(k, 1, 1);
      chk("bp.ovf", overflow, 1);
      chk("bp.perr", proto_err, 0);
      for (int k = 1; k <= 8; k++) pop_chk($sformatf("bp%0d", k), k, k, 0, k == 1 ? 0 : 1, k - 1);
      chk("bp.empty", rec_valid, 0);
      ev(cur, 1, 1);
      chk("bp.next_idx", rec_index, 9);
      chk("bp.ovf_sticky", overflow, 1);
      // timestamp wrap
      do_reset();
      ev(250, 1, 0);
      ev(260, 0, 1);
      pop_chk("wrap", 250, 4, 10, 0, 0);
      // done with empty queue
      do_reset();
      ev(3, 0, 1);
      chk("perr.flag", proto_err, 1);
      pop_chk("perr", 3, 3, 0, 0, 0);
      // same-cycle bypass, empty queue
      do_reset();
      ev(3, 1, 1);
      chk("byp.perr", proto_err, 0);
      pop_chk("byp", 3, 3, 0, 0, 0);
      // stall count, then finish and drain
      do_reset();
      ev(2, 1, 0);
      go_to(5);
      ap_done = 1;
      tick(); tick(); tick();
      ap_continue = 1;
      tick();
      {ap_done, ap_continue} = '0;
      chk("stall.value", rec_stall, EXP_STL);
      finish = 1;
      tick();
      finish = 0;
      chk("fin.pending", all_done, 0);
      pop_chk("stall", 2, 8, 6, 0, 0);
      chk("fin.after_pop", all_done, 0);
      tick();
      chk("fin.adone", all_done, 1);
      tick();
      chk("fin.sticky", all_done, 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ap_ctrl_txn_tracker.md
# ap_ctrl_txn_tracker

Synthesizable per-transaction profiler that sits directly upstream of the cosim module-status monitor. It snoops a kernel's ap_ctrl_chain handshake (ap_start, ap_ready, ap_done, ap_continue) and the bench finish flag, and pairs each accepted start with its completion. It emits one timestamped record per transaction through a valid/ready FIFO, which the monitor drains and dumps to CSV.

## Interface
Parameters:
- TS_W, 32, timestamp/latency/interval width
- REC_DEPTH, 8, record FIFO depth (power of two, ≥2)
- START_DEPTH, 4, outstanding-start queue depth (power of two, ≥1)

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; all state cleared on assertion
- ap_start  in  1  kernel start request
- ap_ready  in  1  kernel accepts start
- ap_done  in  1  kernel completion
- ap_continue  in  1  downstream accepts completion
- finish  in  1  bench end-of-run flag
- rec_valid  out  1  record available
- rec_ready  in  1  consumer accepts record
- rec_start_ts  out  TS_W  timestamp of start acceptance
- rec_end_ts  out  TS_W  timestamp of done acceptance
- rec_latency  out  TS_W  end − start, modulo 2^TS_W
- rec_interval  out  TS_W  start − previous start, modulo 2^TS_W; 0 for first transaction
- rec_stall  out  TS_W  done back-pressure cycles (see Configuration)
- rec_index  out  16  transaction sequence number, wraps at 2^16
- overflow  out  1  sticky: start queue or record FIFO overrun
- proto_err  out  1  sticky: done accepted with no matching start
- all_done  out  1  sticky: finish seen and all records drained

## Operation
- Timestamp counter ts: 0 on reset, +1 every clock, wraps modulo 2^TS_W.
- Start event S = ap_start & ap_ready. Done event D = ap_done & ap_continue.
- On S: push ts into start queue; interval = ts − last_start_ts (0 if no prior start); last_start_ts ← ts.
- On D: pop oldest start entry; build record {start, end=ts, latency, interval, stall, index}; push into record FIFO; index +1.
- S and D same cycle, queue non-empty: D pops oldest, S pushes; both succeed even when queue full.
- S and D same cycle, queue empty: bypass; record uses current ts as start, latency 0.
- D with queue empty and no S: record pushed with start_ts = ts, latency 0, interval 0; proto_err set.
- S with queue full and no D: entry dropped, overflow set.
- Record push with FIFO full and no pop: record dropped, overflow set, index still increments. Push and pop same cycle when full: both succeed.
- Record handshake: transfer when rec_valid & rec_ready; rec_* stable while rec_valid & !rec_ready.
- all_done ← 1 once finish has been sampled high (latched) and record FIFO empty and no D in that cycle.
- Reset mid-operation: queues, FIFO, counters, sticky flags cleared immediately; in-flight transactions discarded.

## Timing
- All outputs registered; reset values: rec_valid 0, all rec_* 0, overflow 0, proto_err 0, all_done 0.
- Latency D → rec_valid: 1 cycle when FIFO empty (record visible the clock after the D edge).
- Throughput: one record accepted and one delivered per cycle.
- Timestamps sampled at the edge where S/D is true; latency of a kernel with start accepted at ts=10 and done at ts=25 is 15.
- all_done rises one cycle after the last record transfer if finish already latched.

## Configuration
- TXN_STALL_COUNT_EN defined: a stall counter increments each cycle ap_done=1 & ap_continue=0, saturates at 2^TS_W−1, is captured into rec_stall on D, and clears to 0 in that cycle.
- Undefined: counter not built; rec_stall tied to 0.

## Test plan
- Single transaction: S at ts=5, D at ts=17, rec_ready=1 → one record start 5, end 17, latency 12, interval 0, index 0; rec_valid high at ts=18 only.
- Pipelined: S at ts 2, 4, 6; D at 10, 12, 14 → latencies 8, 8, 8; intervals 0, 2, 2; indices 0, 1, 2.
- Back-pressure: rec_ready=0, REC_DEPTH+1 completions → first REC_DEPTH records retained in order, overflow=1, rec_index of next delivered record follows the drop.
- Wrap: TS_W=8, S at ts=250, D at ts=260 (wrapped to 4) → latency 10.
- Protocol: D with empty queue → proto_err=1, latency 0; S and D same cycle with empty queue → latency 0, proto_err stays 0.
- Stall (macro defined): ap_done high with ap_continue low 3 cycles, then D → rec_stall 3; macro undefined → rec_stall 0; finish then drain → all_done=1.
